// File: rtl/pbch_pkg.sv
// Shared constants, FSM state type and c_init helper for the PBCH DM-RS Gold generator.
package pbch_pkg;

    localparam int unsigned GOLD_LEN       = 31;
    localparam int unsigned NC_DEFAULT     = 1600;
    localparam int unsigned PBCH_DMRS_NSYM = 144;

    // Bit k of a mask selects register bit k (x(n+k)) into the recursion for x(n+31).
    localparam logic [GOLD_LEN-1:0] X1_TAPS = 31'h0000_0009;
    localparam logic [GOLD_LEN-1:0] X2_TAPS = 31'h0000_000F;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        WARM,
        RUN
    } state_t;

    function automatic logic [GOLD_LEN-1:0] calc_c_init(input logic [9:0] n_id,
                                                        input logic [2:0] i_ssb);
        logic [3:0]  ip1;
        logic [7:0]  np1;
        logic [11:0] prod;
        ip1  = {1'b0, i_ssb} + 4'd1;
        np1  = {1'b0, n_id[9:3], n_id[2]} + 8'd1;
        prod = 12'(ip1) * 12'(np1);
        return {8'd0, prod, 11'd0} + {21'd0, ip1, 6'd0} + {29'd0, n_id[1:0]};
    endfunction

endpackage

// File: rtl/gold_lfsr2.sv
// 31-bit Fibonacci LFSR advancing two sequence positions per clock, taps set by mask.
module gold_lfsr2
    import pbch_pkg::*;
#(
    parameter logic [GOLD_LEN-1:0] TAPS = X1_TAPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [GOLD_LEN-1:0] seed,
    input  logic                advance,
    output logic [1:0]          out2
);

    logic [GOLD_LEN-1:0] q;
    logic                f0;
    logic                f1;

    // f1 uses the same taps shifted by one; every tap is below bit 5, so both
    // new bits come straight from the current register contents.
    always_comb begin
        f0 = ^(q & TAPS);
        f1 = ^((q >> 1) & TAPS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= {f1, f0, q[GOLD_LEN-1:2]};
        end
    end

    assign out2 = q[1:0];

endmodule

// File: rtl/pbch_dmrs_gold_gen.sv
// PBCH DM-RS Gold sequence generator: latches cell/SSB index, warms up, streams NUM_SYM bit pairs.
module pbch_dmrs_gold_gen
    import pbch_pkg::*;
#(
    parameter int unsigned NUM_SYM = PBCH_DMRS_NSYM,
    parameter int unsigned NC      = NC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] n_id,
    input  logic [2:0] i_ssb,
    output logic [1:0] bits,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy
);

    localparam int unsigned CMAX = (NC / 2 > NUM_SYM) ? NC / 2 : NUM_SYM;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] WARM_END = CW'(NC / 2 - 1);
    localparam logic [CW-1:0] RUN_END  = CW'(NUM_SYM - 1);

    state_t        state;
    logic [9:0]    n_id_q;
    logic [2:0]    i_ssb_q;
    logic [CW-1:0] cnt;
    logic          lfsr_load;
    logic          lfsr_adv;
    logic [1:0]    x1_lo;
    logic [1:0]    x2_lo;

    assign lfsr_load = (state == INIT);
    assign lfsr_adv  = (state == WARM) || (state == RUN);
    assign busy      = (state != IDLE);

    gold_lfsr2 #(.TAPS(X1_TAPS)) u_x1 (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (31'd1),
        .advance (lfsr_adv),
        .out2    (x1_lo)
    );

    gold_lfsr2 #(.TAPS(X2_TAPS)) u_x2 (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (calc_c_init(n_id_q, i_ssb_q)),
        .advance (lfsr_adv),
        .out2    (x2_lo)
    );

    // cnt counts warm-up cycles in WARM and emitted pairs in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            n_id_q    <= '0;
            i_ssb_q   <= '0;
            cnt       <= '0;
            bits      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_id_q  <= n_id;
                        i_ssb_q <= i_ssb;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    cnt   <= '0;
                    state <= WARM;
                end
                WARM: begin
                    if (cnt == WARM_END) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    bits      <= x1_lo ^ x2_lo;
                    out_valid <= 1'b1;
                    if (cnt == RUN_END) begin
                        out_last <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbch_dmrs_gold_gen.sv
// Self-checking bench: bit-serial Gold model feeds a scoreboard; table runs plus corner sequences.
module tb_pbch_dmrs_gold_gen;

    localparam int NC_M   = 1600;
    localparam int NSYM_M = 144;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] n_id = '0;
    logic [2:0] i_ssb = '0;
    logic [1:0] bits;
    logic       out_valid;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    logic [2:0] mon_e;

    typedef struct {
        logic [9:0]  n;
        logic [2:0]  i;
        logic [30:0] c;
        int          first;
        int          last;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    pbch_dmrs_gold_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_id      (n_id),
        .i_ssb     (i_ssb),
        .bits      (bits),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Straight bit-serial form of the two recursions, c(n) = x1(n+Nc) ^ x2(n+Nc).
    function automatic void push_expected(input logic [30:0] cinit);
        bit x1[0:2047];
        bit x2[0:2047];
        bit c0;
        bit c1;
        for (int k = 0; k < 31; k++) begin
            x1[k] = (k == 0);
            x2[k] = cinit[k];
        end
        for (int n = 0; n + 31 < 2048; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int m = 0; m < NSYM_M; m++) begin
            c0 = x1[NC_M+2*m] ^ x2[NC_M+2*m];
            c1 = x1[NC_M+2*m+1] ^ x2[NC_M+2*m+1];
            exp_q.push_back({(m == NSYM_M - 1), c1, c0});
        end
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pair actual=%b required=none", {out_last, bits});
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_last, bits} !== mon_e) begin
                    failures++;
                    $display("FAIL pair_last_bits actual=%b required=%b", {out_last, bits}, mon_e);
                end
            end
        end
    end

    task automatic launch(input logic [9:0] n, input logic [2:0] i, input logic [30:0] c);
        push_expected(c);
        n_id  = n;
        i_ssb = i;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic track(input int p0, input int p1, input int p2, input int abort_k,
                         output int first_k, output int last_k,
                         output int n_last, output int busy_gaps);
        int k;
        first_k = -1;
        last_k = -1;
        n_last = 0;
        busy_gaps = 0;
        k = 0;
        while (k < 1100 && last_k < 0) begin
            @(posedge clk);
            #1;
            k++;
            if (k == p0 || k == p1 || k == p2) begin
                start = 1'b1;
                n_id  = 10'd500;
                i_ssb = 3'd5;
            end else begin
                start = 1'b0;
            end
            if (out_valid && first_k < 0) first_k = k;
            if (out_last) begin
                n_last++;
                last_k = k;
            end
            if (k < 945 && !busy) busy_gaps++;
            if (k == abort_k) return;
        end
    endtask

    task automatic check_run(input int first_k, input int last_k, input int n_last,
                             input int busy_gaps, input int exp_first, input int exp_last);
        check("first_valid_edge", 32'(first_k), 32'(exp_first));
        check("out_last_edge", 32'(last_k), 32'(exp_last));
        check("out_last_count", 32'(n_last), 32'd1);
        check("busy_gaps", 32'(busy_gaps), 32'd0);
    endtask

    task automatic check_idle();
        @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_last", 32'(out_last), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int f, l, nl, bg;
        tbl[0] = '{n: 10'd0,    i: 3'd0, c: 31'd2112,    first: 802, last: 945};
        tbl[1] = '{n: 10'd1007, i: 3'd7, c: 31'd4129283, first: 802, last: 945};
        tbl[2] = '{n: 10'd42,   i: 3'd3, c: 31'd90370,   first: 802, last: 945};
        tbl[3] = '{n: 10'd500,  i: 3'd5, c: 31'd1548672, first: 802, last: 945};

        repeat (3) @(posedge clk);
        #1;
        check("rst_bits", 32'(bits), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 4; t++) begin
            launch(tbl[t].n, tbl[t].i, tbl[t].c);
            track(-1, -1, -1, -1, f, l, nl, bg);
            check_run(f, l, nl, bg, tbl[t].first, tbl[t].last);
            check_idle();
        end

        // back-to-back: next start sampled on edge 946
        launch(10'd1, 3'd0, 31'd2113);
        track(-1, -1, -1, -1, f, l, nl, bg);
        check_run(f, l, nl, bg, 802, 945);
        launch(10'd3, 3'd2, 31'd6339);
        track(-1, -1, -1, -1, f, l, nl, bg);
        check_run(f, l, nl, bg, 802, 945);
        check_idle();

        // start pulses while busy, including the edge RUN returns to IDLE
        launch(10'd1, 3'd0, 31'd2113);
        track(802, 902, 944, -1, f, l, nl, bg);
        check_run(f, l, nl, bg, 802, 945);
        check_idle();
        repeat (5) @(posedge clk);
        #1;
        check("no_restart_busy", 32'(busy), 32'd0);
        check("no_restart_valid", 32'(out_valid), 32'd0);

        // asynchronous reset at pair 50
        launch(10'd42, 3'd3, 31'd90370);
        track(-1, -1, -1, 852, f, l, nl, bg);
        check("pre_abort_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_bits", 32'(bits), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_valid", 32'(out_valid), 32'd0);
        launch(10'd42, 3'd3, 31'd90370);
        track(-1, -1, -1, -1, f, l, nl, bg);
        check_run(f, l, nl, bg, 802, 945);
        check_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pbch_dmrs_gold_gen.md
# pbch_dmrs_gold_gen

Generates the 3GPP TS 38.211 §5.2.1 length-31 Gold pseudo-random sequence for PBCH DM-RS, c_init per §7.4.1.4.1. It sits directly upstream of the QPSK mapper in the post-FFT chain and streams 2 bits per cycle (c(2m), c(2m+1)) with a valid strobe. The mapper turns each pair into one reference symbol for channel estimation. One start request produces one full DM-RS sequence of NUM_SYM pairs.

## Interface
- NUM_SYM, 144: number of output bit pairs (QPSK symbols) per request.
- NC, 1600: Gold sequence warm-up offset in bits. Must be even.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse. Sampled only in IDLE; ignored otherwise.
- n_id  in  10  physical cell ID, 0..1007. Latched when start is accepted.
- i_ssb  in  3  SSB index bar (ī_SSB), 0..7. Latched when start is accepted.
- bits  out  2  bits[0] = c(2m), bits[1] = c(2m+1). Wired to the QPSK mapper `in`.
- out_valid  out  1  bits valid this cycle.
- out_last  out  1  high together with out_valid on pair NUM_SYM-1.
- busy  out  1  state != IDLE.

## Operation
- Reset values: bits = 0, out_valid = 0, out_last = 0, busy = 0, state = IDLE, x1 = x2 = 0, counter = 0.
- c_init = 2^11·(i_ssb+1)·(floor(n_id/4)+1) + 2^6·(i_ssb+1) + (n_id mod 4).
  - Unsigned arithmetic. The product fits in 12 bits. The result fits in 31 bits; the maximum is 4129283.
- LFSR layout: each LFSR is a 31-bit register; bit k holds x(n+k).
  - x1 loads 31'd1.
  - x2 loads c_init.
- Two-step advance per cycle. All taps are ≤ bit 4, so there is no intra-cycle dependency.
  - f0 = x1[3]^x1[0]; f1 = x1[4]^x1[1]; x1 <= {f1, f0, x1[30:2]}.
  - g0 = x2[3]^x2[2]^x2[1]^x2[0]; g1 = x2[4]^x2[3]^x2[2]^x2[1]; x2 <= {g1, g0, x2[30:2]}.
  - Output pair: {x1[1]^x2[1], x1[0]^x2[0]}.
- FSM:
  - IDLE: start=1 → latch n_id and i_ssb, go to INIT.
  - INIT: one cycle. Load x1 and x2, clear counter, go to WARM.
  - WARM: advance both LFSRs, no output. After NC/2 cycles, go to RUN.
  - RUN: register the output pair, set out_valid=1, advance both LFSRs, increment counter.
    - On pair NUM_SYM-1, set out_last=1 and go to IDLE.
- out_valid and out_last are registered. They drop on the edge after the last pair. bits holds its last value while out_valid=0.
- There is no backpressure; the downstream mapper accepts one pair per cycle unconditionally.
- start while busy: ignored, with no effect on the latched n_id/i_ssb.
- start on the same edge that RUN returns to IDLE: ignored, because the FSM is not in IDLE on that edge.
- Reset mid-sequence: immediate abort to reset values. No partial output resumes after reset.

## Timing
Edge 0 is the rising edge that samples start=1 in IDLE.
- Edge 1: LFSRs loaded (INIT).
- Edges 2..NC/2+1 (2..801): warm-up, 800 edges.
- Edges NC/2+2..NC/2+NUM_SYM+1 (802..945): out_valid registered high.
  - Pair m appears after edge 802+m.
  - out_last is high after edge 945.
- After edge 946: out_valid = 0, busy = 0. The earliest next start can be sampled on edge 946.
- Latency from start to first valid pair: 802 edges. One request takes 946 cycles in total.
- busy is high from after edge 0 through edge 945.

## Structure
- Shared package pbch_pkg holds:
  - GOLD_LEN = 31.
  - NC_DEFAULT = 1600.
  - PBCH_DMRS_NSYM = 144.
  - The x1/x2 tap masks.
  - A state enum {IDLE, INIT, WARM, RUN}.
- One natural sub-module, gold_lfsr2: a 31-bit register with load/advance controls, parameterised by tap mask, stepping 2 bits per cycle. It is instantiated twice, once for x1 and once for x2.
- Top level holds the FSM, counter, c_init arithmetic and output registers.

## Test plan
- Reset behaviour: assert rst low mid-RUN at pair 50 → all outputs 0 the same cycle. Release rst, then start → a full 144-pair sequence identical to a clean run.
- Basic sequence: n_id=0, i_ssb=0 (c_init = 2112) → out_valid first high after edge 802, exactly 144 consecutive valid cycles, out_last only on the 144th. All 288 bits match the golden model (MATLAB nrPBCHDMRS pre-mapping bits).
- Maximum c_init: n_id=1007, i_ssb=7 (c_init = 4129283, no overflow) → 288 bits match the golden model.
- Start ignored while busy: pulse start with n_id=500 at pairs 0 and 100 of a run with n_id=1 → output unchanged versus an undisturbed n_id=1 run. busy stays high; only one out_last occurs.
- Back-to-back requests: start on edge 946 with n_id=3, i_ssb=2 → a second sequence begins, first valid pair after edge 946+802. The QPSK mapper fed by this block produces ±91/±91 values matching the reference symbols.
